// File: rtl/cond_status_sched.sv
// ID-stage conditional-execution sequencer: NZCV register, ARM condition check,
// S-instruction interlock and post-branch IF/ID flush generation.
module cond_status_sched #(
    parameter int MAX_PEND  = 3,
    parameter int FLUSH_CYC = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       freeze,
    input  logic       id_valid,
    input  logic [3:0] id_cond,
    input  logic       id_s,
    input  logic       id_branch,
    input  logic       exe_status_we,
    input  logic [3:0] exe_status,
    output logic [3:0] status,
    output logic       id_exec,
    output logic       stall,
    output logic       flush,
    output logic [1:0] pend_cnt
);

    localparam logic [3:0] COND_AL = 4'b1110;
    localparam logic [1:0] PEND_MAX = 2'(MAX_PEND);
    localparam logic [1:0] FCNT_INIT = 2'(FLUSH_CYC - 1);

    typedef enum logic {
        RUN   = 1'b0,
        FLUSH = 1'b1
    } state_t;

    state_t     state, state_d;
    logic [1:0] fcnt, fcnt_d;
    logic       flush_q, flush_d;
    logic [3:0] status_q;
    logic [1:0] pend_q;

    logic n, z, c, v;
    logic pass;
    logic issue_s;
    logic in_run;

    assign n = status_q[3];
    assign z = status_q[2];
    assign c = status_q[1];
    assign v = status_q[0];

    always_comb begin
        pass = 1'b0;
        case (id_cond)
            4'b0000: pass = z;
            4'b0001: pass = ~z;
            4'b0010: pass = c;
            4'b0011: pass = ~c;
            4'b0100: pass = n;
            4'b0101: pass = ~n;
            4'b0110: pass = v;
            4'b0111: pass = ~v;
            4'b1000: pass = c & ~z;
            4'b1001: pass = ~c | z;
            4'b1010: pass = (n == v);
            4'b1011: pass = (n != v);
            4'b1100: pass = ~z & (n == v);
            4'b1101: pass = z | (n != v);
            4'b1110: pass = 1'b1;
            default: pass = 1'b0;
        endcase
    end

    assign in_run = (state == RUN);

    // Any conditional op waits for all in-flight flag writers; AL only waits
    // when it would overflow the pending counter itself.
    assign stall = in_run & id_valid
                 & (((id_cond != COND_AL) & (pend_q != 2'd0))
                 | (id_s & (pend_q == PEND_MAX)));

    assign id_exec = in_run & id_valid & ~stall & ~freeze & pass;
    assign issue_s = id_exec & id_s;

    always_comb begin
        state_d = state;
        fcnt_d  = fcnt;
        flush_d = flush_q;
        if (!freeze) begin
            unique case (state)
                RUN: begin
                    if (id_exec & id_branch) begin
                        state_d = FLUSH;
                        flush_d = 1'b1;
                        fcnt_d  = FCNT_INIT;
                    end
                end
                FLUSH: begin
                    if (fcnt == 2'd0) begin
                        state_d = RUN;
                        flush_d = 1'b0;
                    end else begin
                        fcnt_d = fcnt - 2'd1;
                    end
                end
                default: begin
                    state_d = RUN;
                    flush_d = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= RUN;
            fcnt    <= 2'd0;
            flush_q <= 1'b0;
        end else begin
            state   <= state_d;
            fcnt    <= fcnt_d;
            flush_q <= flush_d;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            status_q <= 4'b0000;
            pend_q   <= 2'd0;
        end else if (!freeze) begin
            if (exe_status_we)
                status_q <= exe_status;
            unique case ({issue_s, exe_status_we})
                2'b10:   pend_q <= pend_q + 2'd1;
                2'b01:   if (pend_q != 2'd0) pend_q <= pend_q - 2'd1;
                default: pend_q <= pend_q;
            endcase
        end
    end

    assign status   = status_q;
    assign pend_cnt = pend_q;
    assign flush    = flush_q;

endmodule

// File: tb/tb_cond_status_sched.sv
// Directed bench for cond_status_sched: per-cycle model compare plus
// hand-computed spot checks from the test plan.
module tb_cond_status_sched;

    localparam int FC = 2;
    localparam int MP = 3;

    logic       clk = 1'b0;
    logic       rst;
    logic       freeze;
    logic       id_valid;
    logic [3:0] id_cond;
    logic       id_s;
    logic       id_branch;
    logic       exe_status_we;
    logic [3:0] exe_status;
    logic [3:0] status;
    logic       id_exec;
    logic       stall;
    logic       flush;
    logic [1:0] pend_cnt;

    int checks = 0;
    int failures = 0;

    cond_status_sched #(.MAX_PEND(MP), .FLUSH_CYC(FC)) dut (
        .clk(clk), .rst(rst), .freeze(freeze), .id_valid(id_valid),
        .id_cond(id_cond), .id_s(id_s), .id_branch(id_branch),
        .exe_status_we(exe_status_we), .exe_status(exe_status),
        .status(status), .id_exec(id_exec), .stall(stall),
        .flush(flush), .pend_cnt(pend_cnt)
    );

    always #5 clk = ~clk;

    // Reference model: flags, pending count, remaining flush cycles
    int   m_status;
    int   m_pend;
    int   m_left;
    bit   started = 0;

    function automatic bit arm_pass(input int st, input int cond);
        bit nf, zf, cf, vf;
        nf = st[3]; zf = st[2]; cf = st[1]; vf = st[0];
        case (cond)
            0:  return zf;
            1:  return !zf;
            2:  return cf;
            3:  return !cf;
            4:  return nf;
            5:  return !nf;
            6:  return vf;
            7:  return !vf;
            8:  return cf && !zf;
            9:  return !cf || zf;
            10: return nf == vf;
            11: return nf != vf;
            12: return !zf && (nf == vf);
            13: return zf || (nf != vf);
            14: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    function automatic bit exp_stall();
        if (m_left > 0 || !id_valid) return 1'b0;
        return (id_cond != 4'hE && m_pend != 0) || (id_s && m_pend == MP);
    endfunction

    function automatic bit exp_exec();
        if (m_left > 0 || !id_valid || freeze) return 1'b0;
        if (exp_stall()) return 1'b0;
        return arm_pass(m_status, int'(id_cond));
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    always @(posedge clk) begin
        bit ex;
        ex = exp_exec();
        if (rst) begin
            m_status = 0;
            m_pend = 0;
            m_left = 0;
            started = 1;
        end else if (started && !freeze) begin
            if (m_left > 0) m_left--;
            if (ex && id_branch) m_left = FC;
            if (ex && id_s && !exe_status_we) m_pend++;
            else if (exe_status_we && !(ex && id_s) && m_pend > 0) m_pend--;
            if (exe_status_we) m_status = int'(exe_status);
        end
    end

    always @(negedge clk) begin
        if (started) begin
            chk("model_status", int'(status), m_status);
            chk("model_pend", int'(pend_cnt), m_pend);
            chk("model_flush", int'(flush), int'(m_left > 0));
            chk("model_stall", int'(stall), int'(exp_stall()));
            chk("model_exec", int'(id_exec), int'(exp_exec()));
        end
    end

    task automatic nx();
        @(posedge clk);
        #1;
    endtask

    task automatic setin(input bit vld, input logic [3:0] cond, input bit s,
                         input bit br, input bit we, input logic [3:0] es);
        id_valid = vld; id_cond = cond; id_s = s; id_branch = br;
        exe_status_we = we; exe_status = es;
    endtask

    initial begin
        rst = 1'b1; freeze = 1'b0;
        setin(0, 4'hE, 0, 0, 0, 4'h0);
        nx(); nx();
        rst = 1'b0;

        // reset then AL
        setin(1, 4'hE, 0, 0, 0, 4'h0);
        @(negedge clk);
        chk("rst_status", int'(status), 0);
        chk("rst_pend", int'(pend_cnt), 0);
        chk("al_exec", int'(id_exec), 1);
        chk("al_stall", int'(stall), 0);
        chk("rst_flush", int'(flush), 0);
        nx();

        // S then dependent EQ
        setin(1, 4'hE, 1, 0, 0, 4'h0);
        nx();
        setin(1, 4'h0, 0, 0, 0, 4'h0);
        @(negedge clk);
        chk("dep_pend1", int'(pend_cnt), 1);
        chk("dep_stall", int'(stall), 1);
        chk("dep_exec0", int'(id_exec), 0);
        nx();
        setin(1, 4'h0, 0, 0, 1, 4'b0100);
        nx();
        setin(1, 4'h0, 0, 0, 0, 4'h0);
        @(negedge clk);
        chk("dep_status", int'(status), 4);
        chk("dep_pend0", int'(pend_cnt), 0);
        chk("dep_unstall", int'(stall), 0);
        chk("dep_exec1", int'(id_exec), 1);
        nx();

        // condition sweep
        for (int st = 0; st < 16; st++) begin
            setin(0, 4'hE, 0, 0, 1, 4'(st));
            nx();
            for (int cd = 0; cd < 16; cd++) begin
                setin(1, 4'(cd), 0, 0, 0, 4'h0);
                @(negedge clk);
                if (st == 9 && cd == 13) chk("sw_1001_le", int'(id_exec), 0);
                if (st == 9 && cd == 10) chk("sw_1001_ge", int'(id_exec), 1);
                if (cd == 15) chk("sw_nv", int'(id_exec), 0);
                nx();
            end
        end

        // taken branch, status now 1111
        setin(1, 4'hE, 0, 1, 0, 4'h0);
        @(negedge clk);
        chk("br_exec", int'(id_exec), 1);
        nx();
        setin(1, 4'hE, 0, 0, 0, 4'h0);
        @(negedge clk);
        chk("br_flush1", int'(flush), 1);
        chk("br_exec1", int'(id_exec), 0);
        nx();
        @(negedge clk);
        chk("br_flush2", int'(flush), 1);
        chk("br_exec2", int'(id_exec), 0);
        nx();
        @(negedge clk);
        chk("br_flush3", int'(flush), 0);
        chk("br_exec3", int'(id_exec), 1);
        nx();
        // not-taken NE branch with z=1
        setin(1, 4'h1, 0, 1, 0, 4'h0);
        @(negedge clk);
        chk("nt_exec", int'(id_exec), 0);
        nx();
        setin(0, 4'hE, 0, 0, 0, 4'h0);
        @(negedge clk);
        chk("nt_flush", int'(flush), 0);
        nx();

        // pending saturation
        setin(1, 4'hE, 1, 0, 0, 4'h0);
        nx(); nx(); nx();
        @(negedge clk);
        chk("sat_pend3", int'(pend_cnt), 3);
        chk("sat_stall", int'(stall), 1);
        chk("sat_exec", int'(id_exec), 0);
        nx();
        setin(0, 4'hE, 0, 0, 1, 4'h0);
        nx();
        setin(1, 4'hE, 1, 0, 1, 4'h0);
        nx();
        @(negedge clk);
        chk("simul_pend", int'(pend_cnt), 2);
        setin(0, 4'hE, 0, 0, 1, 4'b0110);
        nx(); nx(); nx();
        setin(0, 4'hE, 0, 0, 0, 4'h0);
        @(negedge clk);
        chk("spur_pend", int'(pend_cnt), 0);
        chk("spur_status", int'(status), 6);
        nx();

        // freeze in FLUSH, then reset while frozen
        setin(1, 4'hE, 1, 0, 0, 4'h0);
        nx();
        setin(1, 4'hE, 1, 1, 0, 4'h0);
        nx();
        freeze = 1'b1;
        setin(1, 4'hE, 0, 0, 1, 4'b1010);
        @(negedge clk);
        chk("frz_flush_a", int'(flush), 1);
        chk("frz_pend_a", int'(pend_cnt), 2);
        nx();
        @(negedge clk);
        chk("frz_flush_b", int'(flush), 1);
        chk("frz_status", int'(status), 6);
        chk("frz_pend_b", int'(pend_cnt), 2);
        rst = 1'b1;
        nx();
        rst = 1'b0; freeze = 1'b0;
        setin(0, 4'hE, 0, 0, 0, 4'h0);
        @(negedge clk);
        chk("rst2_flush", int'(flush), 0);
        chk("rst2_pend", int'(pend_cnt), 0);
        chk("rst2_status", int'(status), 0);
        nx(); nx();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/cond_status_sched.md
Name: cond_status_sched

Overview:
- Sequences conditional execution in the ID stage of the ARM-subset 5-stage pipeline.
- Owns the NZCV status register and evaluates the 4-bit ARM condition field against it.
- Stalls conditional instructions while flag-setting instructions are still in flight.
- Generates the IF/ID flush pulse sequence after a taken branch.

Parameters:
- MAX_PEND, 3: maximum number of flag-setting (S) instructions in flight; pend_cnt width is 2 bits.
- FLUSH_CYC, 1: number of cycles flush stays high after a taken branch; legal range 1..3.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- freeze  in  1  global pipeline freeze (e.g. memory wait); block state holds
- id_valid  in  1  valid instruction present in ID
- id_cond  in  4  ARM condition field {31:28}
- id_s  in  1  instruction writes flags
- id_branch  in  1  instruction is a branch
- exe_status_we  in  1  EX stage writes flags this cycle
- exe_status  in  4  new {N,Z,C,V} from the ALU
- status  out  4  current status register {N,Z,C,V}
- id_exec  out  1  ID instruction issues and executes this cycle
- stall  out  1  hold PC and IF/ID, inject bubble into ID/EX
- flush  out  1  squash IF/ID contents
- pend_cnt  out  2  in-flight S-instruction count

Behaviour:
- Reset (sync, rst=1 at posedge): status=0000, pend_cnt=0, state=RUN, flush=0. rst overrides all other inputs, including mid-flush and mid-stall.
- Condition pass (pass) is combinational on status, standard ARM encoding:
  - 0000 EQ: z; 0001 NE: ~z; 0010 CS: c; 0011 CC: ~c
  - 0100 MI: n; 0101 PL: ~n; 0110 VS: v; 0111 VC: ~v
  - 1000 HI: c&~z; 1001 LS: ~c|z
  - 1010 GE: n==v; 1011 LT: n!=v
  - 1100 GT: ~z&(n==v); 1101 LE: z|(n!=v)
  - 1110 AL: 1; 1111: 0
- FSM states: RUN, FLUSH.
- stall (combinational) = state==RUN & id_valid & ((id_cond!=1110 & pend_cnt!=0) | (id_s & pend_cnt==MAX_PEND)).
- id_exec (combinational) = state==RUN & id_valid & ~stall & ~freeze & pass.
  - An instruction with pass=0 is not issued. stall=0 for it; it becomes a bubble.
- issue_s = id_exec & id_s.
- pend_cnt update, only when freeze=0:
  - +1 on issue_s alone.
  - -1 on exe_status_we alone; saturates at 0, with no underflow.
  - issue_s and exe_status_we in the same cycle: count unchanged.
- status update: status <= exe_status at the posedge where exe_status_we=1 and freeze=0.
  - New flags are visible to pass in the following cycle.
  - No bypass from exe_status to pass.
- Freeze: status, pend_cnt, FSM state and the flush counter all hold. exe_status_we is ignored; upstream holds it asserted until freeze drops. id_exec is forced 0. flush holds its value.
- Branch: id_exec & id_branch at cycle t drives RUN->FLUSH. flush=1 for cycles t+1..t+FLUSH_CYC (registered output), then FLUSH->RUN.
  - In FLUSH, ID contents are ignored: id_exec=0, stall=0.
  - A branch that is also S still increments pend_cnt.
- Flag writeback during FLUSH updates status and pend_cnt normally.
- All registered outputs are glitch-free. Combinational outputs depend only on current inputs and registers.

Test Plan:
- Reset then AL instruction: rst 1 for 2 cycles, then id_valid=1, id_cond=1110, id_s=0 -> status=0000, pend_cnt=0, id_exec=1, stall=0, flush=0.
- S-instruction then EQ dependent:
  - Cycle 0: issue id_s=1, AL -> pend_cnt=1.
  - Cycle 1: id_cond=0000 -> stall=1, id_exec=0.
  - Cycle 2: exe_status_we=1, exe_status=0100 -> status=0100, pend_cnt=0.
  - Cycle 3: stall=0, id_exec=1.
- Condition sweep: load each status 0000..1111 via writeback, then apply all 16 id_cond values with pend_cnt=0 -> id_exec matches the table. Example: status=1001, LE -> 0; status=1001, GE -> 1; cond 1111 always 0.
- Taken branch with FLUSH_CYC=2: id_branch=1, AL, at cycle 5 -> flush=1 in cycles 6-7, id_exec=0 in cycles 6-7, RUN and flush=0 in cycle 8. A not-taken branch (NE with z=1) -> flush stays 0.
- Pending saturation and simultaneous events:
  - Three AL S-instructions back-to-back -> pend_cnt=3.
  - A fourth S-instruction -> stall=1.
  - issue_s together with exe_status_we -> count unchanged.
  - Spurious exe_status_we at pend_cnt=0 -> stays 0.
- Freeze and reset mid-operation:
  - freeze=1 during FLUSH with exe_status_we=1 -> flush, status and pend_cnt hold.
  - rst during FLUSH with pend_cnt=2 -> next cycle flush=0, pend_cnt=0, status=0000.
